// File: rtl/wm8731_i2c_target.sv
// ============================================================================
// Module   : wm8731_i2c_target
// Brief    : I2C write-only target mirroring the WM8731 control port; keeps a
//            shadow of R0-R9 and strobes every completed register write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wm8731_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i2c_scl_i,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    output logic       i2c_sda_t,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       bus_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_ACK_A  = 3'd2,
        S_BYTE0  = 3'd3,
        S_ACK_0  = 3'd4,
        S_BYTE1  = 3'd5,
        S_ACK_1  = 3'd6,
        S_IGNORE = 3'd7
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic [7:0]             r_shift;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_byte0;
    logic                   r_sda_t;
    logic                   r_wr_valid;
    logic [6:0]             r_wr_addr;
    logic [8:0]             r_wr_data;
    logic                   r_busy;
    logic [8:0]             r_regs [0:9];

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte1;
    logic [6:0] w_wr_reg;
    logic [8:0] w_wr_dat;

    function automatic logic [8:0] f_rst_val(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1: f_rst_val = 9'h097;
            4'd2, 4'd3: f_rst_val = 9'h079;
            4'd4:       f_rst_val = 9'h00A;
            4'd5:       f_rst_val = 9'h008;
            4'd6:       f_rst_val = 9'h09F;
            4'd7:       f_rst_val = 9'h00A;
            default:    f_rst_val = 9'h000;
        endcase
    endfunction

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // Bus conditions require SCL high on both samples so an SCL edge never aliases one
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte1    = {r_shift[6:0], w_sda};
    assign w_wr_reg   = r_byte0[7:1];
    assign w_wr_dat   = {r_byte0[0], w_byte1};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 4'd0;
            r_byte0    <= 8'h00;
            r_sda_t    <= 1'b1;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 9'd0;
            r_busy     <= 1'b0;
            for (int i = 0; i < 10; i++) r_regs[i] <= f_rst_val(4'(i));
        end else begin
            r_wr_valid <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_t   <= 1'b1;
                r_busy    <= 1'b1;
            end else if (w_stop) begin
                r_state <= S_IDLE;
                r_sda_t <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            if (r_shift[7:1] == DEV_ADDR && !r_shift[0]) begin
                                r_state <= S_ACK_A;
                                r_sda_t <= 1'b0;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    S_ACK_A, S_ACK_0: begin
                        if (w_scl_fall) begin
                            r_sda_t   <= 1'b1;
                            r_bit_cnt <= 4'd0;
                            r_state   <= (r_state == S_ACK_A) ? S_BYTE0 : S_BYTE1;
                        end
                    end
                    S_BYTE0: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_byte0 <= r_shift;
                            r_sda_t <= 1'b0;
                            r_state <= S_ACK_0;
                        end
                    end
                    S_BYTE1: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte1;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            // Commit on the last data bit so the strobe precedes the ACK
                            if (r_bit_cnt == 4'd7) begin
                                r_wr_valid <= 1'b1;
                                r_wr_addr  <= w_wr_reg;
                                r_wr_data  <= w_wr_dat;
                                if (w_wr_reg == 7'd15) begin
                                    for (int i = 0; i < 10; i++) r_regs[i] <= f_rst_val(4'(i));
                                end else if (w_wr_reg < 7'd10) begin
                                    r_regs[w_wr_reg[3:0]] <= w_wr_dat;
                                end
                            end
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_sda_t <= 1'b0;
                            r_state <= S_ACK_1;
                        end
                    end
                    S_ACK_1: begin
                        if (w_scl_fall) begin
                            r_sda_t <= 1'b1;
                            r_state <= S_IGNORE;
                        end
                    end
                    S_IDLE, S_IGNORE: r_sda_t <= 1'b1;
                    default: begin
                        r_state <= S_IDLE;
                        r_sda_t <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_data = 9'd0;
        if (rd_addr < 4'd10) rd_data = r_regs[rd_addr];
    end

    assign i2c_sda_o = 1'b0;
    assign i2c_sda_t = r_sda_t;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign bus_busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_wm8731_i2c_target.sv
// ============================================================================
// Module   : tb_wm8731_i2c_target
// Brief    : Directed I2C master driving the WM8731 target with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wm8731_i2c_target;

    logic       clk = 1'b0;
    logic       rstn;
    logic       m_scl;
    logic       m_sda;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       sda_o;
    logic       sda_t;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       bus_busy;
    logic       bus_sda;

    int          errors   = 0;
    int          checks   = 0;
    int          strobes  = 0;
    bit          drive_seen = 1'b0;
    logic        prev_v   = 1'b0;
    logic [15:0] sb [$];
    logic [8:0]  c_rst [0:9] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

    always #5 clk = ~clk;

    // Open-drain bus: master and target can only pull low
    assign bus_sda = m_sda & (sda_t | sda_o);

    wm8731_i2c_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i2c_scl_i (m_scl),
        .i2c_sda_i (bus_sda),
        .i2c_sda_o (sda_o),
        .i2c_sda_t (sda_t),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .bus_busy  (bus_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!sda_t) drive_seen = 1'b1;
        if (rstn && wr_valid) begin
            logic [15:0] e;
            strobes++;
            check("wr_valid_width", {31'd0, prev_v}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {25'd0, wr_addr}, {25'd0, e[15:9]});
                check("wr_data", {23'd0, wr_data}, {23'd0, e[8:0]});
            end
        end
        prev_v = wr_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reg(input string tag, input int idx, input logic [8:0] exp);
        rd_addr = 4'(idx);
        #1;
        check(tag, {23'd0, rd_data}, {23'd0, exp});
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            tick(5); m_scl = 1'b1; tick(10); m_scl = 1'b0; tick(5);
        end
        m_sda = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        tick(5); m_scl = 1'b1; tick(5);
        ack = bus_sda;
        tick(5); m_scl = 1'b0; tick(5);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(5); m_scl = 1'b1; tick(5);
        m_sda = 1'b0; tick(5); m_scl = 1'b0; tick(5);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(5); m_scl = 1'b1; tick(5);
        m_sda = 1'b1; tick(10);
    endtask

    task automatic write_reg(input logic [6:0] r, input logic [8:0] d);
        logic a;
        sb.push_back({r, d});
        i2c_start();
        write_byte(8'h34, a);        check("ack_addr", {31'd0, a}, 32'd0);
        write_byte({r, d[8]}, a);    check("ack_byte0", {31'd0, a}, 32'd0);
        write_byte(d[7:0], a);       check("ack_byte1", {31'd0, a}, 32'd0);
        i2c_stop();
    endtask

    initial begin
        logic a;
        int   s0;
        int   n;
        rstn = 1'b0; m_scl = 1'b1; m_sda = 1'b1; rd_addr = 4'd0;
        tick(4);
        rstn = 1'b1;
        tick(4);

        // Reset state
        check("rst_sda_t",    {31'd0, sda_t},    32'd1);
        check("rst_sda_o",    {31'd0, sda_o},    32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_wr_addr",  {25'd0, wr_addr},  32'd0);
        check("rst_wr_data",  {23'd0, wr_data},  32'd0);
        check("rst_bus_busy", {31'd0, bus_busy}, 32'd0);
        for (int i = 0; i < 10; i++) chk_reg("rst_reg", i, c_rst[i]);
        chk_reg("unmapped_12", 12, 9'h000);

        // Basic write R4 = 0x012
        s0 = strobes;
        sb.push_back({7'd4, 9'h012});
        i2c_start();
        check("busy_after_start", {31'd0, bus_busy}, 32'd1);
        write_byte(8'h34, a); check("basic_ack_addr", {31'd0, a}, 32'd0);
        write_byte(8'h08, a); check("basic_ack_b0",   {31'd0, a}, 32'd0);
        write_byte(8'h12, a); check("basic_ack_b1",   {31'd0, a}, 32'd0);
        i2c_stop();
        check("busy_after_stop", {31'd0, bus_busy}, 32'd0);
        check("basic_strobes", strobes - s0, 32'd1);
        chk_reg("basic_r4", 4, 9'h012);

        // Wrong address: NACK throughout, nothing written
        s0 = strobes;
        tick(1); drive_seen = 1'b0;
        i2c_start();
        write_byte(8'h36, a); check("wrong_nack_addr", {31'd0, a}, 32'd1);
        write_byte(8'h08, a); check("wrong_nack_b0",   {31'd0, a}, 32'd1);
        write_byte(8'h55, a); check("wrong_nack_b1",   {31'd0, a}, 32'd1);
        i2c_stop();
        check("wrong_no_drive", {31'd0, drive_seen}, 32'd0);
        check("wrong_strobes", strobes - s0, 32'd0);
        chk_reg("wrong_r4", 4, 9'h012);

        // Read attempt is NACKed and STOP returns to idle
        i2c_start();
        write_byte(8'h35, a); check("read_nack", {31'd0, a}, 32'd1);
        i2c_stop();
        check("read_busy_clear", {31'd0, bus_busy}, 32'd0);

        // Reset register
        write_reg(7'd0, 9'h1FF);
        chk_reg("r0_written", 0, 9'h1FF);
        write_reg(7'd15, 9'h000);
        for (int i = 0; i < 10; i++) chk_reg("r15_reset_reg", i, c_rst[i]);

        // Write to unmapped register 10: strobed, file unchanged
        s0 = strobes;
        write_reg(7'd10, 9'h155);
        check("r10_strobes", strobes - s0, 32'd1);
        for (int i = 0; i < 10; i++) chk_reg("r10_unchanged", i, c_rst[i]);

        // Aborted write by STOP after byte 0
        s0 = strobes;
        i2c_start();
        write_byte(8'h34, a);
        write_byte(8'h08, a);
        i2c_stop();
        check("abort_strobes", strobes - s0, 32'd0);
        chk_reg("abort_r4", 4, 9'h00A);

        // Repeated START after byte 0, then a full write R7 = 0x04A
        s0 = strobes;
        i2c_start();
        write_byte(8'h34, a);
        write_byte(8'h08, a);
        write_reg(7'd7, 9'h04A);
        check("rs_strobes", strobes - s0, 32'd1);
        chk_reg("rs_r7", 7, 9'h04A);
        chk_reg("rs_r4", 4, 9'h00A);

        // Reset while ACKing byte 0
        i2c_start();
        write_byte(8'h34, a);
        send_bits(8'h08);
        n = 0;
        while (sda_t && n < 40) begin tick(1); n++; end
        check("ack0_driven", {31'd0, sda_t}, 32'd0);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_sda_t",    {31'd0, sda_t},    32'd1);
        check("rst_mid_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_mid_wr_addr",  {25'd0, wr_addr},  32'd0);
        check("rst_mid_wr_data",  {23'd0, wr_data},  32'd0);
        check("rst_mid_bus_busy", {31'd0, bus_busy}, 32'd0);
        chk_reg("rst_mid_r7", 7, 9'h00A);
        @(negedge clk);
        rstn = 1'b1;
        tick(2);
        i2c_stop();
        s0 = strobes;
        write_reg(7'd5, 9'h1A5);
        check("post_rst_strobes", strobes - s0, 32'd1);
        chk_reg("post_rst_r5", 5, 9'h1A5);

        tick(5);
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
